// File: rtl/systolic_array_seq_ctrl_if.sv
// Handshake/config bundle between a host and the systolic-array phase sequencer.
// The master side drives start/config/hold/abort; the slave side (the sequencer)
// drives the ctrl-state code, the SRAM read windows and the status pulses.
interface systolic_array_seq_ctrl_if #(
  parameter int CTRL_WIDTH           = 4,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int LOG2_MAX_TILES       = 4
);
  logic                              i_start;
  logic [LOG2_SRAM_BANK_DEPTH:0]     i_k_len;
  logic [LOG2_MAX_TILES:0]           i_num_tiles;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_top_base;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_left_base;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_down_base;
  logic                              i_hold;
  logic                              i_abort;

  logic [CTRL_WIDTH-1:0]             o_ctrl_state;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_top_rd_start;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_top_rd_end;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_left_rd_start;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_left_rd_end;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_down_rd_start;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_down_rd_end;
  logic                              o_busy;
  logic                              o_done;
  logic                              o_aborted;
  logic                              o_err;
  logic [LOG2_MAX_TILES-1:0]         o_tile_idx;

  modport master (
    output i_start, i_k_len, i_num_tiles, i_top_base, i_left_base, i_down_base,
           i_hold, i_abort,
    input  o_ctrl_state, o_top_rd_start, o_top_rd_end, o_left_rd_start, o_left_rd_end,
           o_down_rd_start, o_down_rd_end, o_busy, o_done, o_aborted, o_err, o_tile_idx
  );

  modport slave (
    input  i_start, i_k_len, i_num_tiles, i_top_base, i_left_base, i_down_base,
           i_hold, i_abort,
    output o_ctrl_state, o_top_rd_start, o_top_rd_end, o_left_rd_start, o_left_rd_end,
           o_down_rd_start, o_down_rd_end, o_busy, o_done, o_aborted, o_err, o_tile_idx
  );
endinterface

// File: rtl/systolic_array_seq_ctrl.sv
// Multi-tile phase sequencer for the systolic array. Walks WARMUP/STEADY/DRAIN
// for each tile, publishes per-tile SRAM read windows built from running
// accumulators, and reports done/abort/config-error as one-cycle pulses.
// Every output is a flop; the next-state logic computes next output values.
module systolic_array_seq_ctrl #(
  parameter int NUM_ROW              = 4,
  parameter int NUM_COL              = 4,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int CTRL_WIDTH           = 4,
  parameter int LOG2_MAX_TILES       = 4
) (
  input logic                     clk,
  input logic                     rst,
  systolic_array_seq_ctrl_if.slave bus
);

  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int KW = LOG2_SRAM_BANK_DEPTH + 1;
  localparam int TW = LOG2_MAX_TILES;
  localparam int NW = LOG2_MAX_TILES + 1;
  localparam int CW = 16;

  localparam logic [CTRL_WIDTH-1:0] CS_IDLE   = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] CS_WARMUP = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] CS_STEADY = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] CS_DRAIN  = CTRL_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_STEADY = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [KW-1:0]          k_q, k_d;
  logic [NW-1:0]          nt_q, nt_d;
  logic [TW-1:0]          tile_q, tile_d;
  logic [AW-1:0]          top_s_q, top_s_d, top_e_q, top_e_d;
  logic [AW-1:0]          left_s_q, left_s_d, left_e_q, left_e_d;
  logic [AW-1:0]          down_s_q, down_s_d, down_e_q, down_e_d;
  logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   err_q, err_d;

  logic                   cfg_bad_s;
  logic                   warm_last_s;
  logic                   steady_last_s;
  logic                   drain_last_s;
  logic                   last_tile_s;

  assign cfg_bad_s     = (bus.i_k_len == KW'(0)) || (bus.i_num_tiles == NW'(0));
  assign warm_last_s   = (cnt_q == CW'(NUM_ROW - 1));
  assign steady_last_s = (cnt_q == (CW'(k_q) - CW'(1)));
  assign drain_last_s  = (cnt_q == CW'(NUM_ROW + NUM_COL - 2));
  assign last_tile_s   = ({1'b0, tile_q} == (nt_q - NW'(1)));

  // Next-state, counter, window-accumulator and next-output computation.
  always_comb begin
    // Default: everything holds (this is also the stall behaviour).
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    nt_d      = nt_q;
    tile_d    = tile_q;
    top_s_d   = top_s_q;
    top_e_d   = top_e_q;
    left_s_d  = left_s_q;
    left_e_d  = left_e_q;
    down_s_d  = down_s_q;
    down_e_d  = down_e_q;
    ctrl_d    = ctrl_q;
    busy_d    = busy_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    err_d     = err_q;

    if ((state_q != S_IDLE) && bus.i_abort) begin
      // Abort beats hold and any phase end; windows and tile index are wiped.
      state_d   = S_IDLE;
      cnt_d     = CW'(0);
      tile_d    = TW'(0);
      top_s_d   = AW'(0);
      top_e_d   = AW'(0);
      left_s_d  = AW'(0);
      left_e_d  = AW'(0);
      down_s_d  = AW'(0);
      down_e_d  = AW'(0);
      ctrl_d    = CS_IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
      err_d     = 1'b0;
    end else if ((state_q != S_IDLE) && bus.i_hold) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          ctrl_d    = CS_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          aborted_d = 1'b0;
          err_d     = 1'b0;
          if (bus.i_start) begin
            if (cfg_bad_s) begin
              err_d = 1'b1;
            end else begin
              // Tile 0 windows start at the bases; later tiles accumulate.
              state_d  = S_WARMUP;
              cnt_d    = CW'(0);
              k_d      = bus.i_k_len;
              nt_d     = bus.i_num_tiles;
              tile_d   = TW'(0);
              top_s_d  = bus.i_top_base;
              top_e_d  = bus.i_top_base + AW'(bus.i_k_len) - AW'(1);
              left_s_d = bus.i_left_base;
              left_e_d = bus.i_left_base + AW'(bus.i_k_len) - AW'(1);
              down_s_d = bus.i_down_base;
              down_e_d = bus.i_down_base + AW'(NUM_ROW - 1);
              ctrl_d   = CS_WARMUP;
              busy_d   = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WARMUP: begin
          if (warm_last_s) begin
            state_d = S_STEADY;
            cnt_d   = CW'(0);
            ctrl_d  = CS_STEADY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STEADY: begin
          if (steady_last_s) begin
            state_d = S_DRAIN;
            cnt_d   = CW'(0);
            ctrl_d  = CS_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_last_s) begin
            cnt_d = CW'(0);
            if (last_tile_s) begin
              state_d = S_DONE;
              ctrl_d  = CS_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              // Next tile starts straight away; windows advance by K / NUM_ROW.
              state_d  = S_WARMUP;
              ctrl_d   = CS_WARMUP;
              tile_d   = tile_q + TW'(1);
              top_s_d  = top_s_q + AW'(k_q);
              top_e_d  = top_e_q + AW'(k_q);
              left_s_d = left_s_q + AW'(k_q);
              left_e_d = left_e_q + AW'(k_q);
              down_s_d = down_s_q + AW'(NUM_ROW);
              down_e_d = down_e_q + AW'(NUM_ROW);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          // Start is deliberately not looked at here; the done pulse ends.
          state_d = S_IDLE;
          ctrl_d  = CS_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
        default: begin
          state_d   = S_IDLE;
          cnt_d     = CW'(0);
          ctrl_d    = CS_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          aborted_d = 1'b0;
          err_d     = 1'b0;
        end
      endcase
    end
  end

  // State, configuration, window and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= CW'(0);
      k_q       <= KW'(0);
      nt_q      <= NW'(0);
      tile_q    <= TW'(0);
      top_s_q   <= AW'(0);
      top_e_q   <= AW'(0);
      left_s_q  <= AW'(0);
      left_e_q  <= AW'(0);
      down_s_q  <= AW'(0);
      down_e_q  <= AW'(0);
      ctrl_q    <= CS_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      nt_q      <= nt_d;
      tile_q    <= tile_d;
      top_s_q   <= top_s_d;
      top_e_q   <= top_e_d;
      left_s_q  <= left_s_d;
      left_e_q  <= left_e_d;
      down_s_q  <= down_s_d;
      down_e_q  <= down_e_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_ctrl_state    = ctrl_q;
  assign bus.o_top_rd_start  = top_s_q;
  assign bus.o_top_rd_end    = top_e_q;
  assign bus.o_left_rd_start = left_s_q;
  assign bus.o_left_rd_end   = left_e_q;
  assign bus.o_down_rd_start = down_s_q;
  assign bus.o_down_rd_end   = down_e_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_done          = done_q;
  assign bus.o_aborted       = aborted_q;
  assign bus.o_err           = err_q;
  assign bus.o_tile_idx      = tile_q;

endmodule

// File: doc/systolic_array_seq_ctrl.md
Name: systolic_array_seq_ctrl

Overview:
- Multi-tile phase sequencer for systolic_array_top.
- Replaces hand-driven ctrl-state and SRAM read-range stimulus with a start/done-handshaked FSM.
- Generates the IDLE/WARMUP/STEADY/DRAIN codes and per-tile top/left/down SRAM read windows for a configurable reduction length and tile count.
- Adds hold (stall), abort, and config-error reporting.

Parameters:
- NUM_ROW, 4, PE rows; WARMUP length.
- NUM_COL, 4, PE columns; contributes to DRAIN length.
- LOG2_SRAM_BANK_DEPTH, 5, SRAM address width; all address math is modulo 2^LOG2_SRAM_BANK_DEPTH.
- CTRL_WIDTH, 4, width of the ctrl-state code.
- LOG2_MAX_TILES, 4, tile-count field width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_k_len  in  LOG2_SRAM_BANK_DEPTH+1  reduction length K (legal 1..2^LOG2_SRAM_BANK_DEPTH).
- i_num_tiles  in  LOG2_MAX_TILES+1  tiles to run (legal 1..2^LOG2_MAX_TILES).
- i_top_base / i_left_base / i_down_base  in  LOG2_SRAM_BANK_DEPTH each  base addresses of the three buffers.
- i_hold  in  1  stall: freeze state, counters and outputs.
- i_abort  in  1  return to IDLE.
- o_ctrl_state  out  CTRL_WIDTH  0=IDLE, 1=WARMUP, 2=STEADY, 3=DRAIN.
- o_top_rd_start/o_top_rd_end, o_left_rd_start/o_left_rd_end, o_down_rd_start/o_down_rd_end  out  LOG2_SRAM_BANK_DEPTH each  current tile windows.
- o_busy  out  1  high in WARMUP/STEADY/DRAIN.
- o_done  out  1  one-cycle pulse after the last tile completes.
- o_aborted  out  1  one-cycle pulse on abort.
- o_err  out  1  one-cycle pulse on illegal config.
- o_tile_idx  out  LOG2_MAX_TILES  current tile index.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; config registers cleared.
- Reset has priority over everything and is legal mid-operation.
- Internal states: IDLE, WARMUP, STEADY, DRAIN, DONE. o_ctrl_state shows IDLE during DONE.
- IDLE + i_start:
  - If k_len==0 or num_tiles==0: o_err=1 next cycle, remain IDLE.
  - Otherwise: latch all config inputs; o_ctrl_state=WARMUP and o_busy=1 the next cycle (1-cycle latency).
- Phase durations, counted by a phase counter that resets on every phase entry:
  - WARMUP: NUM_ROW cycles.
  - STEADY: K cycles.
  - DRAIN: NUM_ROW+NUM_COL-1 cycles.
  - Cycles per tile: 2*NUM_ROW + NUM_COL - 1 + K.
- Tile windows, with tile t using running accumulators (no multiplier):
  - top_start = top_base + t*K; top_end = top_start + K - 1.
  - left_start = left_base + t*K; left_end = left_start + K - 1.
  - down_start = down_base + t*NUM_ROW; down_end = down_start + NUM_ROW - 1.
  - All addresses wrap modulo depth; end < start after a wrap is legal.
  - Windows are updated registered on WARMUP entry and stay stable for the whole tile.
- End of DRAIN:
  - If t < num_tiles-1: t++ and enter WARMUP directly, with no idle gap.
  - Otherwise: enter DONE; o_done=1, o_busy=0 for one cycle; then IDLE.
  - i_start during DONE is ignored.
- i_start while busy: ignored; latched config is unchanged by input changes.
- i_hold=1 in a non-IDLE state freezes FSM, counters and all outputs. In IDLE, hold has no effect.
- i_abort=1 in any non-IDLE state (including while held):
  - Next cycle: IDLE, o_busy=0, o_aborted=1, o_done=0, tile index and windows cleared.
  - Abort in IDLE is a no-op.
  - Priority: rst > abort > hold > start.
- i_abort and a phase end in the same cycle: abort wins.

Test Plan:
- Reset mid-DRAIN (rst=1 for 1 cycle) -> next cycle all outputs 0, state IDLE; a later start behaves normally.
- Start with K=4, tiles=1, bases 0/0/0, NUM_ROW=NUM_COL=4 at cycle N:
  - WARMUP at N+1..N+4, STEADY at N+5..N+8, DRAIN at N+9..N+15.
  - o_done at N+16.
  - Windows: top 0..3, left 0..3, down 0..3.
- K=8, tiles=3, top_base=20, down_base=28, depth 32:
  - Tile 2 top window 4..11 (wrapped from 36).
  - Tile 1 down window 0..3 (wrap); tile 2 down window 4..7.
  - No IDLE cycle between tiles.
  - o_tile_idx steps 0,1,2.
- Hold for 3 cycles in STEADY with K=4 -> STEADY lasts 7 cycles; outputs constant during hold; o_done delayed by exactly 3 cycles.
- Abort in tile 1 WARMUP while i_hold=1 -> next cycle IDLE, o_aborted=1, o_done stays 0. A start 2 cycles later runs from tile 0.
- Start with K=0 (and separately tiles=0) -> o_err pulse, o_busy stays 0. i_start asserted during STEADY -> no effect on sequence timing.
